// File: rtl/enigma_char_stream.sv
// Character front/back end for the enigma core: buffers ASCII input, folds letters
// to 0-25 codes, sequences the core issue/sample, and returns grouped uppercase ASCII.
module enigma_char_stream #(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned ENC_LATENCY   = 2,
  parameter int unsigned GROUP_LEN     = 5,
  parameter int unsigned PASS_NONALPHA = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_overflow,
  output logic [4:0] enc_char_out,
  output logic       enc_new_char,
  input  logic [4:0] enc_char_in,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CODE_W = 5;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned WAIT_W = (ENC_LATENCY > 1) ? $clog2(ENC_LATENCY) : 1;
  localparam int unsigned GRP_W  = (GROUP_LEN > 0) ? $clog2(GROUP_LEN + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_ISSUE,
    S_WAIT,
    S_EMIT
  } state_e;

  state_e              state_q, state_d;
  logic [BYTE_W-1:0]   fifo_q [FIFO_DEPTH];
  logic [BYTE_W-1:0]   fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                letter_q, letter_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [GRP_W-1:0]    grp_cnt_q, grp_cnt_d;
  logic [CODE_W-1:0]   enc_char_out_q, enc_char_out_d;
  logic                enc_new_char_q, enc_new_char_d;
  logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic                busy_q, busy_d;

  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic [BYTE_W-1:0]   head_byte;
  logic                head_is_upper;
  logic                head_is_lower;
  logic                head_is_letter;
  logic [CODE_W-1:0]   head_code;
  logic [BYTE_W-1:0]   enc_ascii;
  logic                group_full;

  // Fullness is taken from the registered count, so a same-cycle pop never frees a slot.
  assign fifo_full   = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty  = (count_q == '0);
  assign push        = rx_valid && !fifo_full;
  assign pop         = (state_q == S_IDLE) && !fifo_empty;
  assign rx_overflow = rx_valid && fifo_full && !reset;

  // FIFO storage and pointer update.
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = rx_data;
      wr_ptr_d         = PTR_W'(wr_ptr_q + 1'b1);
    end
    if (pop) begin
      rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
    end
    case ({push, pop})
      2'b10:   count_d = CNT_W'(count_q + 1'b1);
      2'b01:   count_d = CNT_W'(count_q - 1'b1);
      default: count_d = count_q;
    endcase
  end

  // Head-of-FIFO letter classification.
  always_comb begin
    head_byte      = fifo_q[rd_ptr_q];
    head_is_upper  = (head_byte >= 8'h41) && (head_byte <= 8'h5A);
    head_is_lower  = (head_byte >= 8'h61) && (head_byte <= 8'h7A);
    head_is_letter = head_is_upper || head_is_lower;
    head_code      = '0;
    if (head_is_upper) begin
      head_code = CODE_W'(head_byte - 8'h41);
    end else if (head_is_lower) begin
      head_code = CODE_W'(head_byte - 8'h61);
    end
  end

  assign enc_ascii  = (enc_char_in <= 5'd25) ? BYTE_W'(8'h41 + {3'b000, enc_char_in}) : 8'h3F;
  assign group_full = (GROUP_LEN != 0) && (grp_cnt_q == GRP_W'(GROUP_LEN));

  // Character sequencing FSM.
  always_comb begin
    state_d        = state_q;
    code_d         = code_q;
    letter_d       = letter_q;
    wait_cnt_d     = wait_cnt_q;
    grp_cnt_d      = grp_cnt_q;
    enc_char_out_d = enc_char_out_q;
    enc_new_char_d = 1'b0;
    tx_data_d      = tx_data_q;
    tx_valid_d     = tx_valid_q;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          if (head_is_letter) begin
            code_d   = head_code;
            letter_d = 1'b1;
            if (group_full) begin
              tx_data_d  = 8'h20;
              tx_valid_d = 1'b1;
              state_d    = S_GAP;
            end else begin
              enc_char_out_d = head_code;
              enc_new_char_d = 1'b1;
              state_d        = S_ISSUE;
            end
          end else if (PASS_NONALPHA != 0) begin
            letter_d   = 1'b0;
            grp_cnt_d  = '0;
            tx_data_d  = head_byte;
            tx_valid_d = 1'b1;
            state_d    = S_EMIT;
          end
        end
      end

      S_GAP: begin
        if (tx_ready) begin
          tx_valid_d     = 1'b0;
          grp_cnt_d      = '0;
          enc_char_out_d = code_q;
          enc_new_char_d = 1'b1;
          state_d        = S_ISSUE;
        end
      end

      S_ISSUE: begin
        wait_cnt_d = WAIT_W'(ENC_LATENCY - 1);
        state_d    = S_WAIT;
      end

      // Counter reaches zero in the cycle ENC_LATENCY after the pulse; sample the core then.
      S_WAIT: begin
        if (wait_cnt_q == '0) begin
          tx_data_d  = enc_ascii;
          tx_valid_d = 1'b1;
          state_d    = S_EMIT;
        end else begin
          wait_cnt_d = WAIT_W'(wait_cnt_q - 1'b1);
        end
      end

      S_EMIT: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          if (letter_q && (GROUP_LEN != 0) && !group_full) begin
            grp_cnt_d = GRP_W'(grp_cnt_q + 1'b1);
          end
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (count_d != '0) || (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      code_q         <= '0;
      letter_q       <= 1'b0;
      wait_cnt_q     <= '0;
      grp_cnt_q      <= '0;
      enc_char_out_q <= '0;
      enc_new_char_q <= 1'b0;
      tx_data_q      <= '0;
      tx_valid_q     <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      code_q         <= code_d;
      letter_q       <= letter_d;
      wait_cnt_q     <= wait_cnt_d;
      grp_cnt_q      <= grp_cnt_d;
      enc_char_out_q <= enc_char_out_d;
      enc_new_char_q <= enc_new_char_d;
      tx_data_q      <= tx_data_d;
      tx_valid_q     <= tx_valid_d;
      busy_q         <= busy_d;
    end
  end

  assign enc_char_out = enc_char_out_q;
  assign enc_new_char = enc_new_char_q;
  assign tx_data      = tx_data_q;
  assign tx_valid     = tx_valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_enigma_char_stream.sv
// Scoreboard bench for enigma_char_stream: a pass-through and a drop-non-letter instance
// share one rx stream; an enigma stub returns code+1 (or 27 on demand).
module tb_enigma_char_stream;

  localparam int unsigned GROUP_LEN = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       drop_en = 1'b0;
  logic       rx_valid_b;
  logic       tx_ready = 1'b1;
  logic       stub27 = 1'b0;

  logic       rx_overflow, rx_overflow_b;
  logic [4:0] enc_char_out, enc_char_out_b;
  logic       enc_new_char, enc_new_char_b;
  logic [4:0] enc_char_in, enc_char_in_b;
  logic [7:0] tx_data, tx_data_b;
  logic       tx_valid, tx_valid_b;
  logic       busy, busy_b;

  logic [7:0] exp_q[$];
  logic [7:0] exp_b_q[$];
  int unsigned grp_a = 0;
  int unsigned grp_b = 0;
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int ov_cnt = 0;
  int tx_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rx_valid_b    = rx_valid && drop_en;
  assign enc_char_in   = stub27 ? 5'd27 : 5'(enc_char_out + 5'd1);
  assign enc_char_in_b = stub27 ? 5'd27 : 5'(enc_char_out_b + 5'd1);

  enigma_char_stream #(
    .FIFO_DEPTH(4), .ENC_LATENCY(2), .GROUP_LEN(GROUP_LEN), .PASS_NONALPHA(1)
  ) u_dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_overflow(rx_overflow), .enc_char_out(enc_char_out), .enc_new_char(enc_new_char),
    .enc_char_in(enc_char_in), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy)
  );

  enigma_char_stream #(
    .FIFO_DEPTH(4), .ENC_LATENCY(2), .GROUP_LEN(GROUP_LEN), .PASS_NONALPHA(0)
  ) u_dut_drop (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid_b),
    .rx_overflow(rx_overflow_b), .enc_char_out(enc_char_out_b), .enc_new_char(enc_new_char_b),
    .enc_char_in(enc_char_in_b), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
    .tx_ready(tx_ready), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] stub_ascii(input logic [4:0] code);
    logic [4:0] v;
    v = stub27 ? 5'd27 : 5'(code + 5'd1);
    return (v <= 5'd25) ? 8'(8'h41 + 8'(v)) : 8'h3F;
  endfunction

  task automatic push_exp(input logic drop, input logic [7:0] v);
    if (drop) exp_b_q.push_back(v);
    else      exp_q.push_back(v);
  endtask

  // Reference behaviour for one accepted input byte.
  task automatic model(input logic drop, input logic [7:0] b);
    logic        is_up, is_lo;
    logic [4:0]  code;
    int unsigned g;
    is_up = (b >= 8'h41) && (b <= 8'h5A);
    is_lo = (b >= 8'h61) && (b <= 8'h7A);
    g = drop ? grp_b : grp_a;
    if (is_up || is_lo) begin
      code = is_up ? 5'(b - 8'h41) : 5'(b - 8'h61);
      if (g == GROUP_LEN) begin
        push_exp(drop, 8'h20);
        g = 0;
      end
      push_exp(drop, stub_ascii(code));
      if (g < GROUP_LEN) g++;
    end else if (!drop) begin
      push_exp(drop, b);
      g = 0;
    end
    if (drop) grp_b = g;
    else      grp_a = g;
  endtask

  task automatic rx_send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_paced(input logic [7:0] b);
    model(1'b0, b);
    if (drop_en) model(1'b1, b);
    rx_send(b);
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_paced(8'(s[i]));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_b_q.size() != 0 || busy || busy_b) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", 32'(n < 400), 1);
    check("drain_q_empty", 32'(exp_q.size() + exp_b_q.size()), 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    rx_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    exp_b_q.delete();
    grp_a = 0;
    grp_b = 0;
    @(negedge clk);
    check("rst_tx_valid", 32'(tx_valid), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_new_char", 32'(enc_new_char), 0);
    check("rst_char_out", 32'(enc_char_out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_overflow", 32'(rx_overflow), 0);
    check("rst_busy_b", 32'(busy_b || tx_valid_b), 0);
    @(posedge clk); #1;
  endtask

  // Output monitor: scoreboard compare, handshake rules, stall stability, overflow count.
  logic       prev_nc = 1'b0, prev_nc_b = 1'b0;
  logic       stall_a = 1'b0, stall_b = 1'b0;
  logic       hs_a = 1'b0, hs_b = 1'b0;
  logic [7:0] held_a = '0, held_b = '0;

  always @(negedge clk) begin
    if (reset) begin
      stall_a = 1'b0; stall_b = 1'b0;
      hs_a = 1'b0; hs_b = 1'b0;
    end else begin
      if (enc_new_char)   check("new_char_width", 32'(prev_nc), 0);
      if (enc_new_char_b) check("new_char_width_b", 32'(prev_nc_b), 0);
      if (hs_a) check("tx_valid_drop", 32'(tx_valid), 0);
      if (hs_b) check("tx_valid_drop_b", 32'(tx_valid_b), 0);
      if (stall_a && tx_valid)   check("tx_stable", 32'(tx_data), 32'(held_a));
      if (stall_b && tx_valid_b) check("tx_stable_b", 32'(tx_data_b), 32'(held_b));
      if (tx_valid && tx_ready) begin
        tx_cnt++;
        check("tx_data", 32'(tx_data), (exp_q.size() == 0) ? 32'h100 : 32'(exp_q.pop_front()));
      end
      if (tx_valid_b && tx_ready) begin
        check("tx_data_b", 32'(tx_data_b),
              (exp_b_q.size() == 0) ? 32'h100 : 32'(exp_b_q.pop_front()));
      end
      if (rx_overflow) ov_cnt++;
      if (rx_overflow_b) ov_cnt++;
      hs_a    = tx_valid && tx_ready;
      hs_b    = tx_valid_b && tx_ready;
      stall_a = tx_valid && !tx_ready;
      stall_b = tx_valid_b && !tx_ready;
      held_a  = tx_data;
      held_b  = tx_data_b;
    end
    prev_nc   = enc_new_char;
    prev_nc_b = enc_new_char_b;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int t0;
    int vcnt;
    string burst;
    burst = "bcdefg";

    do_reset();

    // Single letter: pulse, code, and sample-to-output latency.
    model(1'b0, 8'h61);
    rx_send(8'h61);
    n = 0;
    while (!enc_new_char && n < 20) begin @(negedge clk); n++; end
    t0 = cyc;
    check("pulse_seen", 32'(enc_new_char), 1);
    check("char_out_a", 32'(enc_char_out), 0);
    n = 0;
    while (!tx_valid && n < 20) begin @(negedge clk); n++; end
    check("tx_latency", 32'(cyc - t0), 3);
    check("first_tx_B", 32'(tx_data), 'h42);
    drain();

    // Grouping, pass/drop of non-letters, classification boundaries.
    do_reset();
    drop_en = 1'b1;
    ov_cnt  = 0;
    send_str("abcdefg");
    drain();
    do_reset();
    send_str("a1 b");
    drain();
    send_str("@AZ[`az{");
    drain();
    for (int i = 0; i < 24; i++) send_paced(8'($urandom_range(0, 255)));
    drain();
    check("no_overflow", 32'(ov_cnt), 0);
    drop_en = 1'b0;

    // Out-of-range core code.
    stub27 = 1'b1;
    send_str("q");
    drain();
    stub27 = 1'b0;

    // Backpressure stall with FIFO overflow.
    do_reset();
    tx_ready = 1'b0;
    ov_cnt   = 0;
    tx_cnt   = 0;
    model(1'b0, 8'h61);
    rx_send(8'h61);
    n = 0;
    while (!tx_valid && n < 50) begin @(negedge clk); n++; end
    check("emit_reached", 32'(tx_valid), 1);
    @(posedge clk); #1;
    for (int i = 0; i < burst.len(); i++) begin
      if (i < 4) model(1'b0, 8'(burst[i]));
      rx_send(8'(burst[i]));
    end
    repeat (8) @(posedge clk);
    #1;
    check("overflow_count", 32'(ov_cnt), 2);
    tx_ready = 1'b1;
    drain();
    check("stall_tx_count", 32'(tx_cnt), 5);

    // Reset while waiting on the core aborts the character and empties the FIFO.
    do_reset();
    rx_send(8'h61);
    rx_send(8'h62);
    n = 0;
    while (!enc_new_char && n < 20) begin @(negedge clk); n++; end
    check("pulse_before_rst", 32'(enc_new_char), 1);
    @(posedge clk); #1;
    do_reset();
    vcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (tx_valid || enc_new_char || busy) vcnt++;
    end
    check("quiet_after_rst", 32'(vcnt), 0);
    @(posedge clk); #1;
    send_str("Zy");
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
